// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the player game-flow controller.
package game_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESPAWN = 3'd1,
        INVULN  = 3'd2,
        PLAY    = 3'd3,
        DYING   = 3'd4,
        OVER    = 3'd5
    } game_state_t;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// One-frame pulse when a given keycode appears in either byte of the report.
module key_edge_detect #(
    parameter logic [7:0] KEY = 8'h28
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] keycode_i,
    output logic        edge_o
);

    logic match;
    logic prev_q;

    // Key present in either report slot, and its rising edge against last frame.
    always_comb begin
        match  = (keycode_i[15:8] == KEY) || (keycode_i[7:0] == KEY);
        edge_o = match && !prev_q;
    end

    // Remember whether the key was down on the previous frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prev_q <= 1'b0;
        else         prev_q <= match;
    end

endmodule

// File: rtl/player_life_ctrl.sv
// Game-flow controller: start, play, death, respawn, invulnerability, game over.
module player_life_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned DEATH_FRAMES  = 60,
    parameter int unsigned INVULN_FRAMES = 120,
    parameter int unsigned BLINK_LOG2    = 3,
    parameter int unsigned NUM_ENEMIES   = 4,
    parameter int unsigned SCORE_W       = 16,
    localparam int unsigned ID_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic [15:0]            keycode,
    input  logic [NUM_ENEMIES-1:0] hit_vec,
    output logic [2:0]             game_state,
    output logic [3:0]             lives,
    output logic [SCORE_W-1:0]     score,
    output logic [ID_W-1:0]        hit_id,
    output logic                   respawn,
    output logic                   move_en,
    output logic                   hit_en,
    output logic                   player_visible,
    output logic                   game_over
);

    localparam int unsigned TMAX = max_u(DEATH_FRAMES, INVULN_FRAMES);
    localparam int unsigned TW   = max_u($clog2(TMAX), BLINK_LOG2 + 1);

    game_state_t        state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [3:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d, score_inc;
    logic [ID_W-1:0]    hit_id_q, hit_id_d, first_hit;
    logic               start_edge;
    logic               respawn_q, respawn_d;
    logic               move_en_q, move_en_d;
    logic               hit_en_q, hit_en_d;
    logic               vis_q, vis_d;
    logic               over_q, over_d;

    key_edge_detect #(.KEY(KEY_ENTER)) u_start (
        .clk_i     (frame_clk),
        .rst_ni    (Reset),
        .keycode_i (keycode),
        .edge_o    (start_edge)
    );

    // Lowest-index meteor overlap; scanning from the top lets lower indices overwrite.
    always_comb begin
        first_hit = '0;
        for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
            if (hit_vec[NUM_ENEMIES-1-i]) first_hit = ID_W'(NUM_ENEMIES - 1 - i);
        end
    end

    // Next state, timer, lives, score and hit index.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        lives_d   = lives_q;
        score_d   = score_q;
        hit_id_d  = hit_id_q;
        score_inc = (&score_q) ? score_q : score_q + 1'b1;
        case (state_q)
            IDLE, OVER: begin
                if (start_edge) begin
                    state_d = RESPAWN;
                    lives_d = 4'(LIVES_INIT);
                    score_d = '0;
                end
            end
            RESPAWN: begin
                state_d = INVULN;
                timer_d = TW'(INVULN_FRAMES - 1);
            end
            INVULN: begin
                score_d = score_inc;
                if (timer_q == '0) state_d = PLAY;
                else               timer_d = timer_q - 1'b1;
            end
            PLAY: begin
                if (|hit_vec) begin
                    hit_id_d = first_hit;
                    if (lives_q <= 4'd1) begin
                        state_d = OVER;
                        lives_d = '0;
                    end else begin
                        state_d = DYING;
                        lives_d = lives_q - 4'd1;
                        timer_d = TW'(DEATH_FRAMES - 1);
                    end
                end else begin
                    score_d = score_inc;
                end
            end
            DYING: begin
                if (timer_q == '0) state_d = RESPAWN;
                else               timer_d = timer_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered copies track the state register.
    always_comb begin
        respawn_d = (state_d == RESPAWN);
        move_en_d = (state_d == INVULN) || (state_d == PLAY);
        hit_en_d  = (state_d == PLAY);
        over_d    = (state_d == OVER);
        case (state_d)
            INVULN:       vis_d = ~timer_d[BLINK_LOG2];
            DYING, OVER:  vis_d = 1'b0;
            default:      vis_d = 1'b1;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            lives_q   <= '0;
            score_q   <= '0;
            hit_id_q  <= '0;
            respawn_q <= 1'b0;
            move_en_q <= 1'b0;
            hit_en_q  <= 1'b0;
            vis_q     <= 1'b1;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            hit_id_q  <= hit_id_d;
            respawn_q <= respawn_d;
            move_en_q <= move_en_d;
            hit_en_q  <= hit_en_d;
            vis_q     <= vis_d;
            over_q    <= over_d;
        end
    end

    assign game_state     = state_q;
    assign lives          = lives_q;
    assign score          = score_q;
    assign hit_id         = hit_id_q;
    assign respawn        = respawn_q;
    assign move_en        = move_en_q;
    assign hit_en         = hit_en_q;
    assign player_visible = vis_q;
    assign game_over      = over_q;

endmodule

// File: tb/tb_player_life_ctrl.sv
// Randomised self-checking bench for player_life_ctrl against a frame-level game model.
`timescale 1ns/1ps
module tb_player_life_ctrl;
    import game_ctrl_pkg::*;

    localparam int LI = 3, DF = 60, IF = 120, BL = 3, NE = 4;

    logic          frame_clk = 1'b0;
    logic          Reset     = 1'b0;
    logic [15:0]   keycode   = '0;
    logic [NE-1:0] hit_vec   = '0;

    logic [2:0]  game_state, game_state2;
    logic [3:0]  lives, lives2;
    logic [15:0] score;
    logic [3:0]  score2;
    logic [1:0]  hit_id, hit_id2;
    logic respawn, move_en, hit_en, player_visible, game_over;
    logic respawn2, move_en2, hit_en2, player_visible2, game_over2;

    player_life_ctrl dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .hit_vec(hit_vec),
        .game_state(game_state), .lives(lives), .score(score), .hit_id(hit_id),
        .respawn(respawn), .move_en(move_en), .hit_en(hit_en),
        .player_visible(player_visible), .game_over(game_over)
    );

    player_life_ctrl #(.SCORE_W(4)) dut_sat (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .hit_vec(hit_vec),
        .game_state(game_state2), .lives(lives2), .score(score2), .hit_id(hit_id2),
        .respawn(respawn2), .move_en(move_en2), .hit_en(hit_en2),
        .player_visible(player_visible2), .game_over(game_over2)
    );

    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        game_state_t st;
        int          lives;
        int          score;
        int          hit_id;
        int          left;
        bit          prev;
    } model_t;

    model_t m1, m2;

    logic [29:0] obs;
    assign obs = {game_state, lives, score, hit_id, respawn, move_en, hit_en, player_visible, game_over};

    function automatic model_t mreset();
        model_t m;
        m.st = IDLE; m.lives = 0; m.score = 0; m.hit_id = 0; m.left = 0; m.prev = 0;
        return m;
    endfunction

    // One frame of the game rules; "left" counts frames remaining in a timed phase.
    function automatic model_t step(model_t m, logic [15:0] kc, logic [NE-1:0] hv, int smax);
        model_t n = m;
        bit now = (kc[15:8] == 8'h28) || (kc[7:0] == 8'h28);
        bit start = now && !m.prev;
        int i = 0;
        n.prev = now;
        case (m.st)
            IDLE, OVER: if (start) begin n.st = RESPAWN; n.lives = LI; n.score = 0; end
            RESPAWN: begin n.st = INVULN; n.left = IF; end
            INVULN: begin
                n.score = (m.score < smax) ? m.score + 1 : smax;
                if (m.left == 1) n.st = PLAY; else n.left = m.left - 1;
            end
            PLAY: begin
                if (hv != 0) begin
                    while (!hv[i]) i++;
                    n.hit_id = i;
                    if (m.lives <= 1) begin n.st = OVER; n.lives = 0; end
                    else begin n.st = DYING; n.lives = m.lives - 1; n.left = DF; end
                end else begin
                    n.score = (m.score < smax) ? m.score + 1 : smax;
                end
            end
            DYING: if (m.left == 1) n.st = RESPAWN; else n.left = m.left - 1;
            default: n.st = IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [29:0] expect_vec(model_t m);
        logic vis;
        case (m.st)
            INVULN:      vis = ((((m.left - 1) >> BL) & 1) == 0);
            DYING, OVER: vis = 1'b0;
            default:     vis = 1'b1;
        endcase
        return {m.st, 4'(m.lives), 16'(m.score), 2'(m.hit_id),
                m.st == RESPAWN, (m.st == INVULN) || (m.st == PLAY), m.st == PLAY, vis, m.st == OVER};
    endfunction

    function automatic logic [7:0] rand_key(bit allow_enter);
        int r = $urandom_range(0, 19);
        case (r)
            0: return 8'h1A;
            1: return 8'h04;
            2: return 8'h16;
            3: return 8'h07;
            19: return allow_enter ? 8'h28 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick(input logic [15:0] kc, input logic [NE-1:0] hv);
        keycode = kc;
        hit_vec = hv;
        @(posedge frame_clk);
        if (Reset) begin
            m1 = step(m1, kc, hv, 65535);
            m2 = step(m2, kc, hv, 15);
        end
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; keycode = '0; hit_vec = '0;
        m1 = mreset(); m2 = mreset();
        repeat (2) @(posedge frame_clk);
        #1;
        n_checks++;
        if (obs !== {IDLE, 4'd0, 16'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL reset_values: got %h expected %h", obs, {IDLE, 27'h2});
        end
        Reset = 1'b1;
        for (int f = 0; f < 10; f++) begin
            tick('0, '0);
            n_checks++;
            if (obs !== expect_vec(m1)) begin
                n_fail++; $display("FAIL idle_frame%0d: got %h expected %h", f, obs, expect_vec(m1));
            end
            n_checks++;
            if (game_state !== IDLE || move_en !== 1'b0 || respawn !== 1'b0 || lives !== 4'd0) begin
                n_fail++; $display("FAIL idle_quiet%0d: state %0d move_en %b respawn %b lives %0d expected IDLE/0/0/0",
                                   f, game_state, move_en, respawn, lives);
            end
        end
    endtask

    task automatic test_start();
        int resp = 0, inv = 0, nruns, bad_runs = 0;
        int runs[$];
        logic lastvis = 1'b0;
        for (int f = 0; f < 200 && game_state != PLAY; f++) begin
            tick((f < 5) ? 16'h0028 : 16'h0000, '0);
            n_checks++;
            if (obs !== expect_vec(m1)) begin
                n_fail++; $display("FAIL start_frame%0d: got %h expected %h", f, obs, expect_vec(m1));
            end
            if (respawn) resp++;
            if (game_state == INVULN) begin
                if (inv == 0 || player_visible != lastvis) runs.push_back(1);
                else runs[runs.size() - 1]++;
                lastvis = player_visible;
                inv++;
            end
        end
        n_checks++;
        if (resp !== 1) begin n_fail++; $display("FAIL start_respawn_pulses: got %0d expected 1", resp); end
        n_checks++;
        if (lives !== 4'd3) begin n_fail++; $display("FAIL start_lives: got %0d expected 3", lives); end
        n_checks++;
        if (inv !== IF) begin n_fail++; $display("FAIL start_invuln_frames: got %0d expected %0d", inv, IF); end
        nruns = runs.size();
        foreach (runs[i]) if (runs[i] != 8) bad_runs++;
        n_checks++;
        if (nruns !== 15 || bad_runs !== 0) begin
            n_fail++; $display("FAIL start_blink: got %0d runs (%0d not 8 long) expected 15 runs of 8", nruns, bad_runs);
        end
        n_checks++;
        if (game_state !== PLAY) begin n_fail++; $display("FAIL start_reach_play: got state %0d expected %0d", game_state, PLAY); end
    endtask

    task automatic test_hit();
        int dying = 1;
        logic [15:0] sc;
        for (int f = 0; f < 3; f++) begin
            tick({rand_key(0), rand_key(0)}, '0);
            n_checks++;
            if (obs !== expect_vec(m1)) begin
                n_fail++; $display("FAIL hit_pre%0d: got %h expected %h", f, obs, expect_vec(m1));
            end
        end
        sc = score;
        tick('0, 4'b0110);
        n_checks++;
        if (hit_id !== 2'd1 || lives !== 4'd2 || move_en !== 1'b0 || game_state !== DYING || score !== sc) begin
            n_fail++; $display("FAIL hit_effect: got id %0d lives %0d move_en %b state %0d score %0d expected 1 2 0 %0d %0d",
                               hit_id, lives, move_en, game_state, score, DYING, sc);
        end
        for (int f = 0; f < 100 && game_state == DYING; f++) begin
            tick('0, '0);
            n_checks++;
            if (obs !== expect_vec(m1)) begin
                n_fail++; $display("FAIL hit_dying%0d: got %h expected %h", f, obs, expect_vec(m1));
            end
            if (game_state == DYING) dying++;
        end
        n_checks++;
        if (dying !== DF) begin n_fail++; $display("FAIL hit_dying_frames: got %0d expected %0d", dying, DF); end
        n_checks++;
        if (respawn !== 1'b1 || game_state !== RESPAWN) begin
            n_fail++; $display("FAIL hit_respawn: got respawn %b state %0d expected 1 %0d", respawn, game_state, RESPAWN);
        end
    endtask

    task automatic test_hit_through_invuln();
        int play_frames = 0, early_loss = 0;
        for (int f = 0; f < 200 && game_state != DYING; f++) begin
            tick('0, 4'($urandom_range(1, 15)));
            n_checks++;
            if (obs !== expect_vec(m1)) begin
                n_fail++; $display("FAIL invuln_hit%0d: got %h expected %h", f, obs, expect_vec(m1));
            end
            if (game_state == INVULN && lives != 4'd2) early_loss++;
            if (game_state == PLAY) play_frames++;
        end
        n_checks++;
        if (early_loss !== 0 || lives !== 4'd1 || play_frames !== 1 || game_state !== DYING) begin
            n_fail++; $display("FAIL invuln_immunity: got losses %0d lives %0d play %0d state %0d expected 0 1 1 %0d",
                               early_loss, lives, play_frames, game_state, DYING);
        end
    endtask

    task automatic test_game_over();
        logic [15:0] sc;
        logic [1:0]  hid;
        for (int f = 0; f < 700 && game_state != OVER; f++) begin
            tick({rand_key(1), rand_key(1)},
                 (f > 300 || $urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
            n_checks++;
            if (obs !== expect_vec(m1)) begin
                n_fail++; $display("FAIL over_run%0d: got %h expected %h", f, obs, expect_vec(m1));
            end
        end
        n_checks++;
        if (game_state !== OVER || lives !== 4'd0 || game_over !== 1'b1) begin
            n_fail++; $display("FAIL over_reached: got state %0d lives %0d game_over %b expected %0d 0 1",
                               game_state, lives, game_over, OVER);
        end
        sc = score; hid = hit_id;
        for (int f = 0; f < 5; f++) begin
            tick({rand_key(0), rand_key(0)}, 4'($urandom_range(0, 15)));
            n_checks++;
            if (score !== sc || hit_id !== hid || game_state !== OVER || obs !== expect_vec(m1)) begin
                n_fail++; $display("FAIL over_hold%0d: got %h expected %h (score %0d hit_id %0d)",
                                   f, obs, expect_vec(m1), sc, hid);
            end
        end
        tick(16'h2800, '0);
        n_checks++;
        if (respawn !== 1'b1 || lives !== 4'd3 || score !== 16'd0 || obs !== expect_vec(m1)) begin
            n_fail++; $display("FAIL over_restart: got %h expected %h", obs, expect_vec(m1));
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 1500; f++) begin
            tick({rand_key(1), rand_key(1)},
                 ($urandom_range(0, 14) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
            n_checks++;
            if (obs !== expect_vec(m1) || score2 !== 4'(m2.score)) begin
                n_fail++; $display("FAIL random%0d: got %h/%h expected %h/%h",
                                   f, obs, score2, expect_vec(m1), 4'(m2.score));
            end
        end
    endtask

    task automatic test_reset_mid();
        Reset = 1'b0;
        #2;
        m1 = mreset(); m2 = mreset();
        Reset = 1'b1;
        tick(16'h0028, '0);
        for (int f = 0; f < 200 && game_state != PLAY; f++) tick('0, '0);
        tick('0, 4'b1000);
        n_checks++;
        if (hit_id !== 2'd3 || game_state !== DYING || obs !== expect_vec(m1)) begin
            n_fail++; $display("FAIL mid_hit: got %h expected %h", obs, expect_vec(m1));
        end
        repeat (10) tick('0, '0);
        #3;
        Reset = 1'b0;
        #1;
        m1 = mreset(); m2 = mreset();
        n_checks++;
        if (obs !== {IDLE, 4'd0, 16'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL mid_async_reset: got %h expected %h", obs, {IDLE, 27'h2});
        end
        @(posedge frame_clk);
        #2;
        Reset = 1'b1;
        for (int f = 0; f < 3; f++) begin
            tick('0, '0);
            n_checks++;
            if (obs !== expect_vec(m1)) begin
                n_fail++; $display("FAIL mid_after%0d: got %h expected %h", f, obs, expect_vec(m1));
            end
        end
    endtask

    task automatic test_saturation();
        tick(16'h0028, '0);
        for (int f = 0; f < 40; f++) begin
            tick('0, '0);
            n_checks++;
            if (score2 !== 4'(m2.score) || obs !== expect_vec(m1)) begin
                n_fail++; $display("FAIL sat_frame%0d: got %h/%h expected %h/%h",
                                   f, obs, score2, expect_vec(m1), 4'(m2.score));
            end
        end
        n_checks++;
        if (score2 !== 4'hF || game_state2 !== INVULN) begin
            n_fail++; $display("FAIL sat_final: got score %h state %0d expected f %0d", score2, game_state2, INVULN);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_hit_through_invuln();
        test_game_over();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
